// File: rtl/i2c_line_receiver.sv
// ---------------------------------------------------------------------------
// i2c_line_receiver
//   Passive I2C bus observer: synchronizes and glitch-filters SCL/SDA,
//   detects START/STOP conditions and assembles received bytes plus the
//   acknowledge bit that follows each byte.
//
// Parameters
//   FILT_LEN   consecutive clk samples (1..15) a synchronized line must
//              differ from its filtered value before the filtered value
//              follows it
//
// Ports
//   clk        system clock, all state updates on its rising edge
//   reset      asynchronous active-high reset
//   scl, sda   raw I2C lines, asynchronous to clk
//   scl_f      filtered SCL
//   sda_f      filtered SDA
//   start_det  one-cycle pulse on START or repeated START
//   stop_det   one-cycle pulse on STOP
//   bus_busy   high from START until STOP
//   byte_data  last completed byte (MSB first on the wire)
//   byte_valid one-cycle pulse when byte_data updates
//   ack_bit    SDA sampled in the 9th clock slot (0 = ACK)
//   ack_valid  one-cycle pulse when ack_bit updates
// ---------------------------------------------------------------------------
module i2c_line_receiver #(
    parameter int unsigned FILT_LEN = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    input  logic       sda,
    output logic       scl_f,
    output logic       sda_f,
    output logic       start_det,
    output logic       stop_det,
    output logic       bus_busy,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       ack_bit,
    output logic       ack_valid
);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        ACK
    } state_t;

    localparam logic [3:0] CNT_MAX = 4'(FILT_LEN - 1);

    // Bit 1 carries SCL, bit 0 carries SDA throughout the line front end.
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] filt;
    logic [1:0] prev;
    logic [3:0] fcnt [2];

    logic scl_p;
    logic sda_p;
    logic scl_rise;
    logic sda_fall;
    logic sda_rise;
    logic start_cond;
    logic stop_cond;

    state_t     state;
    state_t     state_nx;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       shift_en;
    logic       byte_done;
    logic       ack_done;
    logic       clr_bits;

    // Synchronizers, per-line filters and the previous-value copies.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= '1;
            sync2   <= '1;
            filt    <= '1;
            prev    <= '1;
            fcnt[0] <= '0;
            fcnt[1] <= '0;
        end else begin
            sync1 <= {scl, sda};
            sync2 <= sync1;
            prev  <= filt;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == CNT_MAX) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 4'd1;
                end
            end
        end
    end

    assign scl_f = filt[1];
    assign sda_f = filt[0];
    assign scl_p = prev[1];
    assign sda_p = prev[0];

    assign scl_rise = scl_f & ~scl_p;
    assign sda_fall = ~sda_f & sda_p;
    assign sda_rise = sda_f & ~sda_p;

    // Requiring SCL high both now and in the previous cycle means an SDA
    // edge coinciding with an SCL edge is never taken as START/STOP.
    assign start_cond = sda_fall & scl_f & scl_p;
    assign stop_cond  = sda_rise & scl_f & scl_p;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // START/STOP take priority over any scl_rise in the same cycle.
    always_comb begin
        state_nx  = state;
        shift_en  = 1'b0;
        byte_done = 1'b0;
        ack_done  = 1'b0;
        clr_bits  = 1'b0;
        if (start_cond) begin
            state_nx = DATA;
            clr_bits = 1'b1;
        end else if (stop_cond) begin
            state_nx = IDLE;
            clr_bits = 1'b1;
        end else if (scl_rise) begin
            case (state)
                IDLE: ;
                DATA: begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        byte_done = 1'b1;
                        state_nx  = ACK;
                    end
                end
                ACK: begin
                    ack_done = 1'b1;
                    clr_bits = 1'b1;
                    state_nx = DATA;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            ack_bit    <= 1'b1;
            ack_valid  <= 1'b0;
            start_det  <= 1'b0;
            stop_det   <= 1'b0;
            bus_busy   <= 1'b0;
        end else begin
            start_det  <= start_cond;
            stop_det   <= stop_cond;
            byte_valid <= byte_done;
            ack_valid  <= ack_done;
            if (start_cond) begin
                bus_busy <= 1'b1;
            end else if (stop_cond) begin
                bus_busy <= 1'b0;
            end
            if (clr_bits) begin
                bit_cnt <= '0;
                shreg   <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 3'd1;
                shreg   <= {shreg[6:0], sda_f};
            end
            if (byte_done) begin
                byte_data <= {shreg[6:0], sda_f};
            end
            if (ack_done) begin
                ack_bit <= sda_f;
            end
        end
    end

endmodule
